// File: rtl/trig_lfsr_pkg.sv
// Shared types, constants and LFSR step function for the trigger/sequence generator.
package trig_lfsr_pkg;

  // State encoding doubles as the externally visible trigger code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEEN0 = 2'b01,
    ARMED = 2'b11
  } trig_state_e;

  localparam int unsigned LFSR_W = 20;
  localparam int unsigned TAP_HI = 19;
  localparam int unsigned TAP_LO = 16;

  localparam logic [LFSR_W-1:0] DEF_SEED = 20'h00001;
  localparam logic [127:0]      DEF_PAT0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0]      DEF_PAT1 = 128'h00112233445566778899aabbccddeeff;

  // x^20 + x^17 + 1, shift-left Fibonacci form
  function automatic logic [LFSR_W-1:0] lfsr20_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr20_core.sv
// 20-bit maximal-length LFSR with seed load, step enable and wrap detection.
module lfsr20_core
  import trig_lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  output logic [LFSR_W-1:0] q,
  output logic              wrap
);

  logic [LFSR_W-1:0] next_q;

  always_comb begin
    next_q = lfsr20_next(q);
    wrap   = (next_q == SEED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= SEED;
    else if (load) q <= SEED;
    else if (en)   q <= next_q;
  end

endmodule

// File: rtl/trig_lfsr_gen.sv
// Watches the plaintext stream for PAT0 then PAT1, then runs one full LFSR period
// with the trigger code and count exposed to the downstream load stage.
module trig_lfsr_gen
  import trig_lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_SEED,
  parameter logic [127:0]      PAT0 = DEF_PAT0,
  parameter logic [127:0]      PAT1 = DEF_PAT1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [127:0]      data,
  output logic [1:0]        tj_trig,
  output logic [LFSR_W-1:0] counter,
  output logic              active
);

  if (SEED == '0) begin : g_seed_check
    $error("trig_lfsr_gen: SEED must be nonzero");
  end

  trig_state_e state, state_next;
  logic        hit0, hit1, wrap;
  logic        lfsr_load, lfsr_en;

  always_comb begin
    hit0 = data_valid && (data == PAT0);
    hit1 = data_valid && (data == PAT1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hit0) state_next = SEEN0;
      SEEN0: begin
        if (hit1)            state_next = ARMED;
        else if (hit0)       state_next = SEEN0;
        else if (data_valid) state_next = IDLE;
      end
      ARMED:   if (wrap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      active <= (state_next == ARMED);
    end
  end

  // On the wrap cycle the LFSR steps onto SEED itself, so the exit edge shows SEED.
  always_comb begin
    lfsr_en   = (state == ARMED);
    lfsr_load = !lfsr_en;
  end

  lfsr20_core #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .en   (lfsr_en),
    .q    (counter),
    .wrap (wrap)
  );

  assign tj_trig = state;

endmodule

// File: tb/tb_trig_lfsr_gen.sv
// Directed self-checking bench for trig_lfsr_gen.
module tb_trig_lfsr_gen;

  localparam logic [127:0] P0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam int unsigned  PERIOD = 1048575;

  logic         clk = 1'b0;
  logic         rst;
  logic         data_valid;
  logic [127:0] data;
  logic [1:0]   tj_trig;
  logic [19:0]  counter;
  logic         active;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [19:0] exp_cnt;

  trig_lfsr_gen #(
    .SEED (20'h00001),
    .PAT0 (P0),
    .PAT1 (P1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data       (data),
    .tj_trig    (tj_trig),
    .counter    (counter),
    .active     (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] t, input logic [19:0] c,
                         input logic a);
    chk({tag, ".tj_trig"}, 32'(tj_trig), 32'(t));
    chk({tag, ".counter"}, 32'(counter), 32'(c));
    chk({tag, ".active"},  32'(active),  32'(a));
  endtask

  // One rising edge, then settle 1 time unit so outputs reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [127:0] d);
    data_valid = v;
    data       = d;
  endtask

  function automatic logic [19:0] model_next(input logic [19:0] s);
    logic fb;
    fb = s[19] ^ s[16];
    return ((s << 1) & 20'hFFFFF) | {19'd0, fb};
  endfunction

  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1 chk_out(tag, 2'b00, 20'h00001, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    beat(1'b0, '0);
    #3 chk_out("reset_async", 2'b00, 20'h00001, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("reset_hold", 2'b00, 20'h00001, 1'b0);
    end

    // PAT1 alone must not advance
    beat(1'b1, P1); step(); chk_out("idle_pat1", 2'b00, 20'h00001, 1'b0);

    // Arm and first LFSR steps
    beat(1'b1, P0); step(); chk_out("arm_seen0", 2'b01, 20'h00001, 1'b0);
    beat(1'b1, P1); step(); chk_out("arm_entry", 2'b11, 20'h00001, 1'b1);
    beat(1'b0, '0);
    step(); chk_out("arm_step1", 2'b11, 20'h00002, 1'b1);
    step(); chk_out("arm_step2", 2'b11, 20'h00004, 1'b1);
    step(); chk_out("arm_step3", 2'b11, 20'h00008, 1'b1);
    exp_cnt = 20'h00008;
    for (int i = 4; i <= 17; i++) begin
      step();
      exp_cnt = model_next(exp_cnt);
    end
    chk_out("arm_step17", 2'b11, 20'h20001, 1'b1);
    chk("model_step17", 32'(exp_cnt), 32'h20001);

    // Full period with pattern beats presented throughout
    for (int i = 18; i < int'(PERIOD); i++) begin
      beat(1'b1, i[0] ? P0 : P1);
      step();
      exp_cnt = model_next(exp_cnt);
    end
    chk_out("period_last", 2'b11, exp_cnt, 1'b1);
    beat(1'b1, P0); step(); chk_out("period_exit", 2'b00, 20'h00001, 1'b0);
    beat(1'b1, P0); step(); chk_out("post_exit_pat0", 2'b01, 20'h00001, 1'b0);

    // Gaps in SEEN0, then arm and reset mid-ARMED
    beat(1'b0, P1);
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("gap_hold", 2'b01, 20'h00001, 1'b0);
    end
    beat(1'b1, P1); step(); chk_out("gap_arm", 2'b11, 20'h00001, 1'b1);
    beat(1'b0, '0);
    exp_cnt = 20'h00001;
    for (int i = 0; i < 500; i++) begin
      step();
      exp_cnt = model_next(exp_cnt);
    end
    chk_out("armed_500", 2'b11, exp_cnt, 1'b1);
    async_reset("rst_mid_armed");
    chk_out("rst_released", 2'b00, 20'h00001, 1'b0);
    beat(1'b1, P1); step(); chk_out("rearm_pat1_only", 2'b00, 20'h00001, 1'b0);
    beat(1'b1, P0); step(); chk_out("rearm_seen0", 2'b01, 20'h00001, 1'b0);
    beat(1'b1, P1); step(); chk_out("rearm_armed", 2'b11, 20'h00001, 1'b1);
    beat(1'b0, '0);
    async_reset("rst_second");

    // Abort in SEEN0 on a non-matching valid beat
    beat(1'b1, P0);  step(); chk_out("abort_seen0", 2'b01, 20'h00001, 1'b0);
    beat(1'b1, '0);  step(); chk_out("abort_zero",  2'b00, 20'h00001, 1'b0);
    beat(1'b1, P1);  step(); chk_out("abort_pat1",  2'b00, 20'h00001, 1'b0);

    // Repeated prefix
    beat(1'b1, P0); step(); chk_out("rep_p0a", 2'b01, 20'h00001, 1'b0);
    beat(1'b1, P0); step(); chk_out("rep_p0b", 2'b01, 20'h00001, 1'b0);
    beat(1'b1, P1); step(); chk_out("rep_p1",  2'b11, 20'h00001, 1'b1);
    beat(1'b0, '0); step(); chk_out("rep_step1", 2'b11, 20'h00002, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
